// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the ID-stage pipeline logic and the stall/flush
// sequencer. The pipeline side (master) supplies hazard and memory status;
// the sequencer side (slave) returns enables, selects and status flags.
interface pipeline_stall_ctrl_if;

  // Hazard-detection inputs sampled from the EX and ID stages
  logic        memread_ex;
  logic [4:0]  rd_ex;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic        uses_rs2_id;
  logic        branch_taken_id;
  logic        mem_busy;

  // Pipeline control returned by the sequencer
  logic        pc_write;
  logic        pc_sel_branch;
  logic        if_id_write;
  logic        if_id_flush;
  logic        control_sel;
  logic        pipe_freeze;
  logic        timeout_err;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  modport master (
    output memread_ex, rd_ex, rs1_id, rs2_id, uses_rs2_id, branch_taken_id, mem_busy,
    input  pc_write, pc_sel_branch, if_id_write, if_id_flush, control_sel,
           pipe_freeze, timeout_err, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  memread_ex, rd_ex, rs1_id, rs2_id, uses_rs2_id, branch_taken_id, mem_busy,
    output pc_write, pc_sel_branch, if_id_write, if_id_flush, control_sel,
           pipe_freeze, timeout_err, perf_stall_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for a 5-stage pipeline, placed beside ID.
// Handles load-use bubbles (LOAD_LAT per hazard), taken-branch IF/ID flush
// and whole-pipe freeze while data memory is busy, with a sticky timeout
// flag for excessively long memory waits.
// Optional feature macro: STALL_PERF_EN enables the 32-bit stall and flush
// performance counters; without it the perf outputs are constant zero.
module pipeline_stall_ctrl #(
  parameter int LOAD_LAT = 2,   // bubbles per load-use hazard, 1..7
  parameter int MAX_WAIT = 255  // busy cycles before timeout_err, 1..255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_stall_ctrl_if.slave sc
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  // Bubbles still owed after the first one, which is issued from RUN
  localparam logic [2:0] LU_INIT      = 3'(LOAD_LAT - 1);
  localparam bit         MULTI_BUBBLE = (LOAD_LAT > 1);
  localparam logic [7:0] WAIT_LIMIT   = 8'(MAX_WAIT);

  state_t     state_reg;
  logic [2:0] lu_cnt_reg;
  logic [7:0] wait_cnt_reg;
  logic [7:0] wait_cnt_next;
  logic       timeout_reg;
  logic       hazard;

  logic       pc_write;
  logic       pc_sel_branch;
  logic       if_id_write;
  logic       if_id_flush;
  logic       control_sel;
  logic       pipe_freeze;

  // Load-use detection: x0 never creates a dependency, rs2 only when read
  always_comb begin
    hazard = sc.memread_ex && (sc.rd_ex != 5'd0) &&
             ((sc.rd_ex == sc.rs1_id) ||
              (sc.uses_rs2_id && (sc.rd_ex == sc.rs2_id)));
  end

  // Same-cycle control decode; priority is reset > freeze > bubble > branch
  always_comb begin
    pc_write      = 1'b0;
    pc_sel_branch = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    control_sel   = 1'b0;
    pipe_freeze   = 1'b0;
    if (!rst_n) begin
      // Inject bubbles and hold PC/IF-ID while the core is held in reset
      control_sel = 1'b1;
    end else if (sc.mem_busy) begin
      pipe_freeze = 1'b1;
    end else if ((state_reg == LU_STALL) || hazard) begin
      control_sel = 1'b1;
    end else if (sc.branch_taken_id) begin
      pc_write      = 1'b1;
      pc_sel_branch = 1'b1;
      if_id_flush   = 1'b1;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end
  end

  // Bubble sequencer: a freeze holds both the state and the bubble count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= RUN;
      lu_cnt_reg <= 3'd0;
    end else if (!sc.mem_busy) begin
      case (state_reg)
        RUN: begin
          if (hazard && MULTI_BUBBLE) begin
            state_reg  <= LU_STALL;
            lu_cnt_reg <= LU_INIT;
          end
        end
        LU_STALL: begin
          // Last owed bubble: go back to RUN so the next hazard is re-evaluated
          if (lu_cnt_reg <= 3'd1) begin
            state_reg  <= RUN;
            lu_cnt_reg <= 3'd0;
          end else begin
            lu_cnt_reg <= lu_cnt_reg - 3'd1;
          end
        end
        default: begin
          state_reg  <= RUN;
          lu_cnt_reg <= 3'd0;
        end
      endcase
    end
  end

  // Saturating count of consecutive busy cycles
  always_comb begin
    wait_cnt_next = (wait_cnt_reg == 8'hFF) ? wait_cnt_reg : (wait_cnt_reg + 8'd1);
  end

  // Memory-wait watchdog; the flag latches the edge the count reaches the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= 8'd0;
      timeout_reg  <= 1'b0;
    end else if (sc.mem_busy) begin
      wait_cnt_reg <= wait_cnt_next;
      if (wait_cnt_next >= WAIT_LIMIT) begin
        timeout_reg <= 1'b1;
      end
    end else begin
      wait_cnt_reg <= 8'd0;
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_flush_reg;

  // Performance counters: bubble/freeze cycles and IF/ID flushes, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_reg <= 32'd0;
      perf_flush_reg <= 32'd0;
    end else begin
      if (control_sel || pipe_freeze) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
      if (if_id_flush) begin
        perf_flush_reg <= perf_flush_reg + 32'd1;
      end
    end
  end

  assign sc.perf_stall_cnt = perf_stall_reg;
  assign sc.perf_flush_cnt = perf_flush_reg;
`else
  assign sc.perf_stall_cnt = 32'd0;
  assign sc.perf_flush_cnt = 32'd0;
`endif

  assign sc.pc_write      = pc_write;
  assign sc.pc_sel_branch = pc_sel_branch;
  assign sc.if_id_write   = if_id_write;
  assign sc.if_id_flush   = if_id_flush;
  assign sc.control_sel   = control_sel;
  assign sc.pipe_freeze   = pipe_freeze;
  assign sc.timeout_err   = timeout_reg;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (LOAD_LAT=2, MAX_WAIT=4).
// Each step queues the expected output vector, then compares it on the
// falling edge; perf counters are checked just after the following rising edge.
// Vector order: {pc_write, pc_sel_branch, if_id_write, if_id_flush,
//                control_sel, pipe_freeze, timeout_err}
module tb_pipeline_stall_ctrl;

  logic clk;
  logic rst_n;

  pipeline_stall_ctrl_if sc();

  pipeline_stall_ctrl #(
    .LOAD_LAT(2),
    .MAX_WAIT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sc   (sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] V_RUN    = 7'b1010000;
  localparam logic [6:0] V_BUBBLE = 7'b0000100;
  localparam logic [6:0] V_BRANCH = 7'b1101000;
  localparam logic [6:0] V_FREEZE = 7'b0000010;
  localparam logic [6:0] V_TO     = 7'b0000001;

  logic [6:0]  obs_vec;
  logic [6:0]  exp_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int unsigned model_stall = 0;
  int unsigned model_flush = 0;

  assign obs_vec = {sc.pc_write, sc.pc_sel_branch, sc.if_id_write, sc.if_id_flush,
                    sc.control_sel, sc.pipe_freeze, sc.timeout_err};

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u2, input logic br,
                       input logic busy);
    sc.memread_ex      = mr;
    sc.rd_ex           = rd;
    sc.rs1_id          = rs1;
    sc.rs2_id          = rs2;
    sc.uses_rs2_id     = u2;
    sc.branch_taken_id = br;
    sc.mem_busy        = busy;
  endtask

  task automatic check_vec(input string tag);
    logic [6:0] e;
    e = exp_q.pop_front();
    compared++;
    assert (obs_vec === e) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs_vec, e);
    end
  endtask

  task automatic check_perf(input string tag);
    logic [31:0] es;
    logic [31:0] ef;
`ifdef STALL_PERF_EN
    es = model_stall;
    ef = model_flush;
`else
    es = 32'd0;
    ef = 32'd0;
`endif
    compared++;
    assert (sc.perf_stall_cnt === es) else begin
      mismatched++;
      $error("FAIL %s_stall_cnt: observed %0d expected %0d", tag, sc.perf_stall_cnt, es);
    end
    compared++;
    assert (sc.perf_flush_cnt === ef) else begin
      mismatched++;
      $error("FAIL %s_flush_cnt: observed %0d expected %0d", tag, sc.perf_flush_cnt, ef);
    end
  endtask

  // One clock cycle: inputs already driven, expectation queued, compared mid-cycle
  task automatic step(input string tag, input logic [6:0] e);
    exp_q.push_back(e);
    @(negedge clk);
    check_vec(tag);
    @(posedge clk);
    #1;
    if (e[2] || e[1]) model_stall++;
    if (e[3]) model_flush++;
    check_perf(tag);
  endtask

  initial begin
    // Reset with a hazard and a branch present: outputs must be the forced set
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0);
    #2;
    exp_q.push_back(V_BUBBLE);
    check_vec("reset_out");
    check_perf("reset");
    @(posedge clk);
    #1;
    exp_q.push_back(V_BUBBLE);
    check_vec("reset_hold_out");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Normal flow
    step("idle0", V_RUN);
    step("idle1", V_RUN);

    // lw x5 in EX, add x6,x5,x1 in ID: exactly two bubbles
    drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0);
    step("lu_rs1_b1", V_BUBBLE);
    drive(1'b0, 5'd0, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0);   // branch ignored in LU_STALL
    step("lu_rs1_b2", V_BUBBLE);
    drive(1'b0, 5'd0, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0);
    step("lu_rs1_resume", V_RUN);

    // Hazard through rs2, inputs held the whole time
    drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
    step("lu_rs2_b1", V_BUBBLE);
    step("lu_rs2_b2", V_BUBBLE);
    drive(1'b0, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
    step("lu_rs2_resume", V_RUN);

    // Non-hazards
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    step("rd_x0_no_stall", V_RUN);
    drive(1'b1, 5'd9, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0);
    step("rs2_unused_no_stall", V_RUN);
    drive(1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0);
    step("not_load_no_stall", V_RUN);

    // Taken branch: single-cycle flush
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    step("branch_flush", V_BRANCH);
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    step("branch_after", V_RUN);

    // Hazard beats branch
    drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0);
    step("haz_over_branch_b1", V_BUBBLE);
    step("haz_over_branch_b2", V_BUBBLE);
    drive(1'b0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
    step("haz_over_branch_resume", V_RUN);

    // Freeze for 3 cycles inside LU_STALL: still two bubbles, five stall cycles
    drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0);
    step("frz_lu_b1", V_BUBBLE);
    drive(1'b0, 5'd0, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1);
    step("frz_lu_f1", V_FREEZE);
    step("frz_lu_f2", V_FREEZE);
    step("frz_lu_f3", V_FREEZE);
    drive(1'b0, 5'd0, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0);
    step("frz_lu_b2", V_BUBBLE);
    step("frz_lu_resume", V_RUN);

    // Freeze in RUN over a hazard: state must not advance during the freeze
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1);
    step("frz_run_haz", V_FREEZE);
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    step("frz_run_haz_b1", V_BUBBLE);
    drive(1'b0, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    step("frz_run_haz_b2", V_BUBBLE);
    step("frz_run_haz_resume", V_RUN);

    // Freeze beats branch, branch taken once the freeze lifts
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    step("frz_branch", V_FREEZE);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("frz_branch_release", V_BRANCH);

    // Six busy cycles: timeout visible from the fifth cycle, then sticky
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("wait1", V_FREEZE);
    step("wait2", V_FREEZE);
    step("wait3", V_FREEZE);
    step("wait4", V_FREEZE);
    step("wait5_timeout", V_FREEZE | V_TO);
    step("wait6_timeout", V_FREEZE | V_TO);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("timeout_sticky1", V_RUN | V_TO);
    step("timeout_sticky2", V_RUN | V_TO);

    // Reset in the middle of LU_STALL abandons the stall and clears timeout
    drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0);
    step("rst_lu_b1", V_BUBBLE | V_TO);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    exp_q.push_back(V_BUBBLE | V_TO);
    check_vec("rst_lu_in_stall");
    rst_n = 1'b0;
    #1;
    exp_q.push_back(V_BUBBLE);
    check_vec("rst_mid_out");
    model_stall = 0;
    model_flush = 0;
    check_perf("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_q.push_back(V_RUN);
    check_vec("rst_release_run");
    @(posedge clk);
    #1;
    step("post_rst_run", V_RUN);

    compared++;
    assert (exp_q.size() === 0) else begin
      mismatched++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
